// File: rtl/fs_request_sequencer.sv
// rtl/fs_request_sequencer.sv - turns one request into a filesystem name stream, a strobe and a response
//
// Ports:
//   CLOCK_50, reset_n            clock; synchronous active-low reset
//   req_valid/req_ready          request handshake (req_ready high only while idle)
//   req_op                       0 READ, 1 WRITE, 2 DELETE, 3 reserved (answered with an error)
//   req_name                     NUL-terminated name, byte k at [8k+7:8k]
//   req_addr, req_data           word address and write data
//   resp_valid/resp_ready        response handshake; resp_data and resp_err hold until taken
//   fs_filename                  name chunks, four bytes per cycle, zero outside the name phase
//   fs_address, fs_data          presented in the issue cycle and held afterwards
//   fs_rden, fs_wren, fs_del     one-cycle strobes
//   fs_q                         read data, sampled at the edge ending the READ_LATENCY-th
//                                cycle after the fs_rden cycle
//
// Optional build macro FS_NAME_CACHE_EN: remembers the last fully streamed name so that a
// READ/WRITE to the same name skips the name phase. A DELETE invalidates it.
module fs_request_sequencer #(
    parameter int NAME_BYTES   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [8*NAME_BYTES-1:0] req_name,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic                    resp_err,
    output logic [31:0]             fs_filename,
    output logic [31:0]             fs_address,
    output logic [31:0]             fs_data,
    output logic                    fs_rden,
    output logic                    fs_wren,
    output logic                    fs_del,
    input  logic [31:0]             fs_q
);

    localparam int NCH = NAME_BYTES / 4;
    localparam int CW  = $clog2(NCH + 2);
    localparam int WW  = $clog2(READ_LATENCY + 1);
    localparam int NW  = 8 * NAME_BYTES;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NAME,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [NW-1:0]  name_q, name_d;
    logic [1:0]     op_q, op_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [CW-1:0]  chunk_idx_q, chunk_idx_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;

    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_data_q, resp_data_d;
    logic           resp_err_q, resp_err_d;
    logic [31:0]    fs_filename_q, fs_filename_d;
    logic [31:0]    fs_address_q, fs_address_d;
    logic [31:0]    fs_data_q, fs_data_d;
    logic           fs_rden_q, fs_rden_d;
    logic           fs_wren_q, fs_wren_d;
    logic           fs_del_q, fs_del_d;

`ifdef FS_NAME_CACHE_EN
    logic [NW-1:0]  cache_name_q, cache_name_d;
    logic           cache_valid_q, cache_valid_d;

    // Equal up to and including the request's first NUL; bytes after it are don't-care.
    function automatic logic name_match(input logic [NW-1:0] a, input logic [NW-1:0] b);
        logic live;
        logic match;
        live  = 1'b1;
        match = 1'b1;
        for (int i = 0; i < NAME_BYTES; i++) begin
            if (live && (a[8*i +: 8] != b[8*i +: 8])) match = 1'b0;
            if (a[8*i +: 8] == 8'h00) live = 1'b0;
        end
        return match;
    endfunction
`endif

    // Chunk index NCH is the trailing all-zero chunk sent when the name has no NUL.
    function automatic logic [31:0] chunk_of(input logic [NW-1:0] name, input logic [CW-1:0] idx);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == idx) c = name[32*i +: 32];
        end
        return c;
    endfunction

    function automatic logic has_nul(input logic [31:0] c);
        return (c[7:0] == 8'h00) || (c[15:8] == 8'h00) ||
               (c[23:16] == 8'h00) || (c[31:24] == 8'h00);
    endfunction

    always_comb begin
        state_d     = state_q;
        name_d      = name_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chunk_idx_d = chunk_idx_q;
        wait_cnt_d  = wait_cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
`ifdef FS_NAME_CACHE_EN
        cache_name_d  = cache_name_q;
        cache_valid_d = cache_valid_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    name_d      = req_name;
                    op_d        = req_op;
                    addr_d      = req_addr;
                    data_d      = req_data;
                    chunk_idx_d = '0;
                    if ((req_op == OP_RSVD) || (req_name[7:0] == 8'h00)) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else begin
                        state_d = S_NAME;
`ifdef FS_NAME_CACHE_EN
                        if (cache_valid_q && (req_op != OP_DELETE) &&
                            name_match(req_name, cache_name_q)) begin
                            state_d = S_ISSUE;
                        end
`endif
                    end
                end
            end
            S_NAME: begin
                if (has_nul(chunk_of(name_q, chunk_idx_q))) begin
                    state_d = S_ISSUE;
`ifdef FS_NAME_CACHE_EN
                    cache_name_d  = name_q;
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    chunk_idx_d = chunk_idx_q + CW'(1);
                end
            end
            S_ISSUE: begin
`ifdef FS_NAME_CACHE_EN
                if (op_q == OP_DELETE) cache_valid_d = 1'b0;
`endif
                if (op_q == OP_READ) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    state_d     = S_RESP;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WW'(READ_LATENCY - 1)) begin
                    state_d     = S_RESP;
                    resp_data_d = fs_q;
                    resp_err_d  = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d     = S_IDLE;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        req_ready_d   = (state_d == S_IDLE);
        resp_valid_d  = (state_d == S_RESP);
        fs_filename_d = (state_d == S_NAME) ? chunk_of(name_d, chunk_idx_d) : 32'h0;
        fs_rden_d     = (state_d == S_ISSUE) && (op_d == OP_READ);
        fs_wren_d     = (state_d == S_ISSUE) && (op_d == OP_WRITE);
        fs_del_d      = (state_d == S_ISSUE) && (op_d == OP_DELETE);
        fs_address_d  = (state_d == S_ISSUE) ? addr_d : fs_address_q;
        fs_data_d     = (state_d == S_ISSUE) ? data_d : fs_data_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            name_q        <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            chunk_idx_q   <= '0;
            wait_cnt_q    <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            fs_filename_q <= '0;
            fs_address_q  <= '0;
            fs_data_q     <= '0;
            fs_rden_q     <= 1'b0;
            fs_wren_q     <= 1'b0;
            fs_del_q      <= 1'b0;
`ifdef FS_NAME_CACHE_EN
            cache_name_q  <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            name_q        <= name_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            chunk_idx_q   <= chunk_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            fs_filename_q <= fs_filename_d;
            fs_address_q  <= fs_address_d;
            fs_data_q     <= fs_data_d;
            fs_rden_q     <= fs_rden_d;
            fs_wren_q     <= fs_wren_d;
            fs_del_q      <= fs_del_d;
`ifdef FS_NAME_CACHE_EN
            cache_name_q  <= cache_name_d;
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign fs_filename = fs_filename_q;
    assign fs_address  = fs_address_q;
    assign fs_data     = fs_data_q;
    assign fs_rden     = fs_rden_q;
    assign fs_wren     = fs_wren_q;
    assign fs_del      = fs_del_q;

endmodule

// File: doc/fs_request_sequencer.md
FS_REQUEST_SEQUENCER -- requirements
Module: fs_request_sequencer

Interface
REQ-001 Parameter NAME_BYTES, default 32: request file-name capacity in bytes; a multiple of 4, at least 4.
REQ-002 Parameter READ_LATENCY, default 1: cycles from the rden cycle to the edge where q is sampled; at least 1.
REQ-003 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  request handshake; transfer occurs when both are high.
REQ-006 req_op  in  2  0 READ, 1 WRITE, 2 DELETE, 3 reserved.
REQ-007 req_name  in  8*NAME_BYTES  NUL-terminated name; byte k is at [8k+7:8k].
REQ-008 req_addr / req_data  in / in  32 / 32  word address and write data.
REQ-009 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-010 resp_data / resp_err  out / out  32 / 1  read word; error flag.
REQ-011 fs_filename / fs_address / fs_data  out / out / out  32 / 32 / 32  to filesystem filename, address and data.
REQ-012 fs_rden / fs_wren / fs_del  out / out / out  1 / 1 / 1  to filesystem strobes.
REQ-013 fs_q  in  32  from filesystem q.

Function
REQ-014 FSM states SHALL be IDLE, NAME, ISSUE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-015 On accept, name, op, addr and data SHALL be latched; the next state SHALL be NAME, or RESP with resp_err=1 if byte 0 is NUL or op=3.
REQ-016 NAME SHALL drive chunk k = latched bytes 4k..4k+3 on fs_filename (byte 4k in bits [7:0]) in consecutive cycles from k=0.
REQ-017 NAME SHALL end after the first chunk containing a NUL; if no NUL exists in NAME_BYTES, one extra all-zero chunk SHALL follow.
REQ-018 fs_filename SHALL be 0 in every state except NAME.
REQ-019 ISSUE SHALL last exactly 1 cycle, asserting exactly one strobe per op, with fs_address=addr and fs_data=data; strobes SHALL be 0 in every other cycle.
REQ-020 After ISSUE, READ SHALL go to WAIT and capture fs_q into resp_data at its READ_LATENCY-th edge, then go to RESP; WRITE and DELETE SHALL go directly to RESP with resp_data=0.
REQ-021 In RESP, resp_valid SHALL be high; resp_data and resp_err SHALL be stable until resp_ready; on handshake the FSM SHALL return to IDLE.
REQ-022 Name-to-strobe latency SHALL be ceil((NUL index+1)/4) NAME cycles followed by 1 ISSUE cycle; an accepted request SHALL never be dropped.
REQ-023 fs_address and fs_data SHALL hold their last values outside ISSUE.

Reset
REQ-024 With reset_n low at an edge, the state SHALL go to IDLE and all outputs SHALL be 0 except req_ready=1; this SHALL hold in any state, with any in-flight request discarded.
REQ-025 After reset, the first request SHALL always stream its name.

Configuration
REQ-026 Macro FS_NAME_CACHE_EN: when defined, the last fully streamed name SHALL be kept with a valid bit, and an accepted READ/WRITE whose name matches up to and including its NUL SHALL skip NAME and go directly to ISSUE.
REQ-027 With FS_NAME_CACHE_EN, a DELETE SHALL always stream its name and SHALL clear the valid bit in its ISSUE cycle; reset SHALL clear the valid bit.
REQ-028 Without FS_NAME_CACHE_EN, every request SHALL stream its name and no cache storage SHALL exist.

Verification
REQ-029 WRITE name "ab", addr 5, data 0xDEADBEEF -> one NAME cycle with fs_filename=0x00006261, then fs_wren=1, fs_address=5, fs_data=0xDEADBEEF, then resp_valid with resp_err=0.
REQ-030 READ name "abcd", addr 5, fs_q model returning 0xDEADBEEF after 1 cycle -> chunks 0x64636261 then 0x00000000, fs_rden for 1 cycle, resp_data=0xDEADBEEF.
REQ-031 Name with byte 0 NUL, or op=3 -> no fs_* activity, resp_err=1 on the next cycle.
REQ-032 resp_ready held low 10 cycles -> resp_valid and resp_data stable, req_ready low, no strobes.
REQ-033 reset_n low during the second NAME cycle -> all outputs 0 next edge; the next request streams its full name from chunk 0.
REQ-034 FS_NAME_CACHE_EN: two READs of "log" -> the second has no NAME cycle; a DELETE of "log" then a READ of "log" -> that READ streams its name.
